// File: rtl/mul_div_sequencer.sv
// Iterative unsigned multiplier/divider: shift-add MUL and restoring DIV,
// one bit per clock, with abort, back-to-back start and divide-by-zero bypass.
module mul_div_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic             abort,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0]    IDLE     = 2'd0;
    localparam logic [1:0]    CALC     = 2'd1;
    localparam logic [1:0]    DONE     = 2'd2;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]         state_r;
    logic [CW-1:0]      cnt_r;
    logic               op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH:0]     rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic               busy_r;
    logic               done_r;
    logic               dbz_r;
    logic [WIDTH-1:0]   res_lo_r;
    logic [WIDTH-1:0]   res_hi_r;

    logic               accept_s;
    logic               dz_s;
    logic               last_s;
    logic               load_s;
    logic               step_s;
    logic               finish_s;
    logic [1:0]         state_nxt_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] acc_nxt_s;
    logic [WIDTH:0]     rem_shift_s;
    logic [WIDTH:0]     rem_diff_s;
    logic [WIDTH:0]     rem_nxt_s;
    logic [WIDTH-1:0]   quo_nxt_s;

    assign accept_s = start & ~abort;
    assign dz_s     = op & (op2 == {WIDTH{1'b0}});
    assign last_s   = (cnt_r == LAST_CNT);

    // Datapath for one iteration; the borrow out of the WIDTH+1 bit subtract picks restore vs keep
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                      (acc_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        acc_nxt_s   = {mul_sum_s, acc_r[WIDTH-1:1]};
        rem_shift_s = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
        rem_diff_s  = rem_shift_s - {1'b0, b_r};
        if (rem_diff_s[WIDTH]) begin
            rem_nxt_s = rem_shift_s;
        end else begin
            rem_nxt_s = rem_diff_s;
        end
        quo_nxt_s   = {quo_r[WIDTH-2:0], ~rem_diff_s[WIDTH]};
    end

    // Next-state decode plus the load/step/finish strobes that steer the datapath
    always_comb begin
        state_nxt_s = IDLE;
        load_s      = 1'b0;
        step_s      = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = dz_s ? DONE : CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else begin
                    step_s      = 1'b1;
                    finish_s    = last_s;
                    state_nxt_s = last_s ? DONE : CALC;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and status flags, registered so busy/done come straight from flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == CALC);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Operand capture at acceptance and per-clock iteration of both algorithms
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
            op_r  <= 1'b0;
            a_r   <= {WIDTH{1'b0}};
            b_r   <= {WIDTH{1'b0}};
            acc_r <= {(2*WIDTH){1'b0}};
            rem_r <= {(WIDTH+1){1'b0}};
            quo_r <= {WIDTH{1'b0}};
        end else if (load_s) begin
            cnt_r <= {CW{1'b0}};
            op_r  <= op;
            a_r   <= op1;
            b_r   <= op2;
            acc_r <= {{WIDTH{1'b0}}, op2};
            rem_r <= {(WIDTH+1){1'b0}};
            quo_r <= op1;
        end else if (step_s) begin
            cnt_r <= cnt_r + CNT_ONE;
            acc_r <= acc_nxt_s;
            rem_r <= rem_nxt_s;
            quo_r <= quo_nxt_s;
        end
    end

    // Result registers change only when DONE is entered; abort leaves them untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_lo_r <= {WIDTH{1'b0}};
            res_hi_r <= {WIDTH{1'b0}};
            dbz_r    <= 1'b0;
        end else if (load_s && dz_s) begin
            res_lo_r <= {WIDTH{1'b1}};
            res_hi_r <= op1;
            dbz_r    <= 1'b1;
        end else if (finish_s) begin
            dbz_r <= 1'b0;
            if (op_r) begin
                res_lo_r <= quo_nxt_s;
                res_hi_r <= rem_nxt_s[WIDTH-1:0];
            end else begin
                res_lo_r <= acc_nxt_s[WIDTH-1:0];
                res_hi_r <= acc_nxt_s[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign result_lo   = res_lo_r;
    assign result_hi   = res_hi_r;

endmodule
